// File: rtl/lcd_bus_responder.sv
// HD44780-style display-side responder for the 8-bit enable/rs/rw/data bus.
// Latency: the strobe is latched on the enable rise and acts on the fall; read data is valid from the cycle after the rise.
// Backpressure: busy flag (BUSY_CYCLES after an op, DEPTH cycles for clear); transactions ending while busy pulse cmd_err.
module lcd_bus_responder #(
    parameter int ADDR_W      = 5,
    parameter int BUSY_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              rs,
    input  logic              rw,
    input  logic [7:0]        data_in,
    output logic [7:0]        data_out,
    output logic              data_oe,
    output logic              busy,
    output logic [ADDR_W-1:0] addr,
    output logic              display_on,
    output logic              cursor_on,
    output logic              blink_on,
    output logic              incr,
    output logic              shift,
    output logic              cmd_err,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [7:0]        dbg_data
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = (BUSY_CYCLES > 1) ? $clog2(BUSY_CYCLES) : 1;
    localparam logic [CNT_W-1:0] BUSY_LOAD = CNT_W'(BUSY_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_STROBE, S_BUSY, S_CLEAR} state_t;

    state_t            state_q;
    logic              enable_q, act_q;
    logic              rs_q, rw_q;
    logic [7:0]        dat_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] addr_q, clr_q;
    logic [7:0]        data_out_q;
    logic              data_oe_q, disp_q, curs_q, blink_q, incr_q, shift_q, cmd_err_q;
    logic [7:0]        mem [DEPTH];

    logic              enable_rise, enable_fall, busy_w, is_status, exec_w, reject_w, act_d;
    logic [ADDR_W-1:0] addr_step_d;
    logic [7:0]        status_d;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_wa;
    logic [7:0]        mem_wd;

    // Strobe edge detection and transaction classification.
    always_comb begin
        enable_rise = enable & ~enable_q;
        // A fall only counts if a rise opened the transaction.
        enable_fall = ~enable & enable_q & act_q;
        busy_w      = (state_q == S_BUSY) || (state_q == S_CLEAR);
        is_status   = ~rs_q & rw_q;
        exec_w      = enable_fall & (state_q == S_STROBE);
        reject_w    = enable_fall & busy_w & ~is_status;
        act_d       = enable_rise | (act_q & ~enable_fall);
        addr_step_d = incr_q ? addr_q + ADDR_W'(1) : addr_q - ADDR_W'(1);
        status_d    = {busy_w, 7'(addr_q)};
        mem_we      = ~rst & ((state_q == S_CLEAR) | (exec_w & rs_q & ~rw_q));
        mem_wa      = (state_q == S_CLEAR) ? clr_q : addr_q;
        mem_wd      = (state_q == S_CLEAR) ? 8'h20 : dat_q;
    end

    // Bus front end, instruction decode and busy/clear sequencing.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            enable_q   <= 1'b1;
            act_q      <= 1'b0;
            rs_q       <= 1'b0;
            rw_q       <= 1'b0;
            dat_q      <= 8'h00;
            cnt_q      <= '0;
            addr_q     <= '0;
            clr_q      <= '0;
            data_out_q <= 8'h00;
            data_oe_q  <= 1'b0;
            disp_q     <= 1'b0;
            curs_q     <= 1'b0;
            blink_q    <= 1'b0;
            incr_q     <= 1'b1;
            shift_q    <= 1'b0;
            cmd_err_q  <= 1'b0;
        end else begin
            enable_q  <= enable;
            act_q     <= act_d;
            cmd_err_q <= reject_w;

            if (enable_rise) begin
                rs_q      <= rs;
                rw_q      <= rw;
                dat_q     <= data_in;
                data_oe_q <= rw;
                if (rw) data_out_q <= rs ? mem[addr_q] : status_d;
            end else if (enable_fall) begin
                data_oe_q <= 1'b0;
            end else if (act_q && is_status) begin
                // Keep a held status read tracking busy/addr.
                data_out_q <= status_d;
            end

            case (state_q)
                S_IDLE: begin
                    if (enable_rise) state_q <= S_STROBE;
                end
                S_STROBE: begin
                    if (enable_fall) begin
                        if (rs_q) begin
                            addr_q  <= addr_step_d;
                            state_q <= S_BUSY;
                            cnt_q   <= BUSY_LOAD;
                        end else if (rw_q) begin
                            state_q <= S_IDLE;
                        end else begin
                            state_q <= S_BUSY;
                            cnt_q   <= BUSY_LOAD;
                            casez (dat_q)
                                8'b1???????: addr_q <= dat_q[ADDR_W-1:0];
                                8'b01??????: state_q <= S_IDLE;
                                8'b001?????: ;
                                8'b0001????: ;
                                8'b00001???: begin
                                    disp_q  <= dat_q[2];
                                    curs_q  <= dat_q[1];
                                    blink_q <= dat_q[0];
                                end
                                8'b000001??: begin
                                    incr_q  <= dat_q[1];
                                    shift_q <= dat_q[0];
                                end
                                8'b0000001?: addr_q <= '0;
                                8'b00000001: begin
                                    addr_q  <= '0;
                                    incr_q  <= 1'b1;
                                    clr_q   <= '0;
                                    state_q <= S_CLEAR;
                                end
                                default: state_q <= S_IDLE;
                            endcase
                        end
                    end
                end
                S_BUSY: begin
                    if (cnt_q == '0) state_q <= act_d ? S_STROBE : S_IDLE;
                    else             cnt_q   <= cnt_q - CNT_W'(1);
                end
                S_CLEAR: begin
                    if (&clr_q) state_q <= act_d ? S_STROBE : S_IDLE;
                    else        clr_q   <= clr_q + ADDR_W'(1);
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // DDRAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_wa] <= mem_wd;
    end

    assign dbg_data   = mem[dbg_addr];
    assign data_out   = data_out_q;
    assign data_oe    = data_oe_q;
    assign busy       = busy_w;
    assign addr       = addr_q;
    assign display_on = disp_q;
    assign cursor_on  = curs_q;
    assign blink_on   = blink_q;
    assign incr       = incr_q;
    assign shift      = shift_q;
    assign cmd_err    = cmd_err_q;

endmodule

// File: tb/tb_lcd_bus_responder.sv
// Directed bench for lcd_bus_responder: table of bus operations plus hand-written busy/reset sequences.
module tb_lcd_bus_responder;

    logic       clk = 1'b0;
    logic       rst, enable, rs, rw;
    logic [7:0] data_in, data_out, dbg_data;
    logic       data_oe, busy, display_on, cursor_on, blink_on, incr, shift, cmd_err;
    logic [4:0] addr, dbg_addr;

    int errors = 0;
    int checks = 0;

    lcd_bus_responder #(.ADDR_W(5), .BUSY_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .enable(enable), .rs(rs), .rw(rw), .data_in(data_in),
        .data_out(data_out), .data_oe(data_oe), .busy(busy), .addr(addr),
        .display_on(display_on), .cursor_on(cursor_on), .blink_on(blink_on),
        .incr(incr), .shift(shift), .cmd_err(cmd_err), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit         rs;
        bit         rw;
        logic [7:0] d;
        logic [4:0] ea;   // expected addr afterwards
        logic [4:0] ef;   // expected {display,cursor,blink,incr,shift}
        int         eb;   // expected busy length in cycles
        logic [7:0] er;   // expected read data (reads only)
    } vec_t;

    typedef struct {
        logic [4:0] a;
        logic [7:0] d;
    } mem_t;

    vec_t tbl[19];
    mem_t mtbl[5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            tick();
        end
    endtask

    // One full transaction: rise, fall, then count busy cycles.
    task automatic bus_op(input bit r_s, input bit r_w, input logic [7:0] d,
                          output int blen, output logic [7:0] rd);
        rs = r_s; rw = r_w; data_in = d; enable = 1'b1;
        tick();
        rd = data_out;
        enable = 1'b0;
        tick();
        wait_idle(blen);
    endtask

    function automatic logic [4:0] flags();
        return {display_on, cursor_on, blink_on, incr, shift};
    endfunction

    initial begin
        int         blen;
        logic [7:0] rd;

        tbl[0]  = '{1'b0, 1'b0, 8'h06, 5'd0,  5'b00010, 4, 8'h00};
        tbl[1]  = '{1'b1, 1'b0, 8'h48, 5'd1,  5'b00010, 4, 8'h00};
        tbl[2]  = '{1'b1, 1'b0, 8'h49, 5'd2,  5'b00010, 4, 8'h00};
        tbl[3]  = '{1'b0, 1'b0, 8'h9F, 5'd31, 5'b00010, 4, 8'h00};
        tbl[4]  = '{1'b1, 1'b0, 8'h41, 5'd0,  5'b00010, 4, 8'h00};
        tbl[5]  = '{1'b1, 1'b0, 8'h42, 5'd1,  5'b00010, 4, 8'h00};
        tbl[6]  = '{1'b0, 1'b0, 8'h04, 5'd1,  5'b00000, 4, 8'h00};
        tbl[7]  = '{1'b0, 1'b0, 8'h80, 5'd0,  5'b00000, 4, 8'h00};
        tbl[8]  = '{1'b1, 1'b0, 8'h55, 5'd31, 5'b00000, 4, 8'h00};
        tbl[9]  = '{1'b0, 1'b0, 8'h0D, 5'd31, 5'b10100, 4, 8'h00};
        tbl[10] = '{1'b0, 1'b0, 8'h40, 5'd31, 5'b10100, 0, 8'h00};
        tbl[11] = '{1'b0, 1'b0, 8'h00, 5'd31, 5'b10100, 0, 8'h00};
        tbl[12] = '{1'b0, 1'b0, 8'h07, 5'd31, 5'b10111, 4, 8'h00};
        tbl[13] = '{1'b0, 1'b0, 8'h02, 5'd0,  5'b10111, 4, 8'h00};
        tbl[14] = '{1'b0, 1'b0, 8'h20, 5'd0,  5'b10111, 4, 8'h00};
        tbl[15] = '{1'b0, 1'b0, 8'h10, 5'd0,  5'b10111, 4, 8'h00};
        tbl[16] = '{1'b0, 1'b0, 8'h0A, 5'd0,  5'b01011, 4, 8'h00};
        tbl[17] = '{1'b1, 1'b1, 8'h00, 5'd1,  5'b01011, 4, 8'h55};
        tbl[18] = '{1'b0, 1'b1, 8'h00, 5'd1,  5'b01011, 0, 8'h01};

        mtbl[0] = '{5'd0,  8'h55};
        mtbl[1] = '{5'd1,  8'h49};
        mtbl[2] = '{5'd2,  8'h20};
        mtbl[3] = '{5'd3,  8'h20};
        mtbl[4] = '{5'd31, 8'h41};

        // Reset with enable (a data read) held high across release.
        rst = 1'b1; enable = 1'b1; rs = 1'b1; rw = 1'b1; data_in = 8'h00; dbg_addr = 5'd0;
        tick(); tick(); tick();
        check("rst_data_out", data_out, 8'h00);
        check("rst_data_oe", data_oe, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_addr", addr, 5'd0);
        check("rst_flags", flags(), 5'b00010);
        check("rst_cmd_err", cmd_err, 1'b0);
        rst = 1'b0;
        tick(); tick();
        check("held_enable_no_rise_oe", data_oe, 1'b0);
        enable = 1'b0;
        tick(); tick();
        check("held_enable_no_action_busy", busy, 1'b0);
        check("held_enable_no_action_addr", addr, 5'd0);

        // Clear display: busy exactly DEPTH cycles, all cells become space.
        bus_op(1'b0, 1'b0, 8'h01, blen, rd);
        check("clear_busy_len", blen, 32);
        check("clear_addr", addr, 5'd0);
        check("clear_incr", incr, 1'b1);
        for (int a = 0; a < 32; a++) begin
            dbg_addr = a[4:0];
            #1;
            check($sformatf("clear_mem[%0d]", a), dbg_data, 8'h20);
        end

        // Table of bus operations.
        for (int i = 0; i < 19; i++) begin
            bus_op(tbl[i].rs, tbl[i].rw, tbl[i].d, blen, rd);
            check($sformatf("v%0d_addr", i), addr, tbl[i].ea);
            check($sformatf("v%0d_flags", i), flags(), tbl[i].ef);
            check($sformatf("v%0d_busy_len", i), blen, tbl[i].eb);
            if (tbl[i].rw) check($sformatf("v%0d_read", i), rd, tbl[i].er);
        end
        for (int i = 0; i < 5; i++) begin
            dbg_addr = mtbl[i].a;
            #1;
            check($sformatf("mem[%0d]", mtbl[i].a), dbg_data, mtbl[i].d);
        end

        // Writes while busy are rejected; status reads still answer.
        rs = 1'b0; rw = 1'b0; data_in = 8'h20; enable = 1'b1;
        tick();
        enable = 1'b0;
        tick();
        check("busy_after_fnset", busy, 1'b1);
        rs = 1'b1; rw = 1'b0; data_in = 8'h77; enable = 1'b1;
        tick();
        enable = 1'b0;
        tick();
        check("busy_write_cmd_err", cmd_err, 1'b1);
        rs = 1'b0; rw = 1'b1; enable = 1'b1;
        tick();
        check("cmd_err_one_cycle", cmd_err, 1'b0);
        check("busy_status_read", data_out, 8'h81);
        check("busy_status_oe", data_oe, 1'b1);
        enable = 1'b0;
        tick();
        check("status_no_cmd_err", cmd_err, 1'b0);
        check("status_oe_drop", data_oe, 1'b0);
        wait_idle(blen);
        dbg_addr = 5'd1;
        #1;
        check("rejected_write_mem", dbg_data, 8'h49);
        check("rejected_write_addr", addr, 5'd1);

        // Held status read keeps data_oe high.
        rs = 1'b0; rw = 1'b1; enable = 1'b1;
        tick(); tick(); tick(); tick();
        check("held_read_oe", data_oe, 1'b1);
        check("held_read_data", data_out, 8'h01);
        enable = 1'b0;
        tick(); tick();
        check("held_read_oe_drop", data_oe, 1'b0);

        // Display control then reset in the middle of a clear.
        bus_op(1'b0, 1'b0, 8'h0D, blen, rd);
        check("dctl_display_on", display_on, 1'b1);
        check("dctl_cursor_on", cursor_on, 1'b0);
        check("dctl_blink_on", blink_on, 1'b1);
        rs = 1'b0; rw = 1'b0; data_in = 8'h01; enable = 1'b1;
        tick();
        enable = 1'b0;
        tick();
        tick(); tick(); tick(); tick(); tick();
        check("mid_clear_busy", busy, 1'b1);
        rst = 1'b1;
        tick();
        check("mid_clear_rst_busy", busy, 1'b0);
        check("mid_clear_rst_addr", addr, 5'd0);
        rst = 1'b0;
        tick(); tick(); tick();
        dbg_addr = 5'd0;
        #1;
        check("mid_clear_mem0", dbg_data, 8'h20);
        dbg_addr = 5'd31;
        #1;
        check("mid_clear_mem31_kept", dbg_data, 8'h41);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
